matrix_scan_driver: RTL and testbench



---
 rtl/matrix_scan_driver.sv | 139 +++++++++++++
 tb/tb_matrix_scan_driver.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// Row-scanned LED matrix driver: double-buffered 16x12 frame, serial column
// shift-out (sclk/sdata/slatch) and row decoder control (row_sel/row_en).
module matrix_scan_driver #(
  parameter int COLS        = 16,
  parameter int ROWS        = 12,
  parameter int CLK_DIV     = 2,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ack,
  output logic                 frame_start,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 slatch,
  output logic [3:0]           row_sel,
  output logic                 row_en
);

  localparam int BIT_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int FRAME_W = ROWS * COLS;

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_HOLD
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  shadow;
  logic [FRAME_W-1:0]  display;
  logic [FRAME_W-1:0]  src_frame;
  logic                pending;
  logic [3:0]          row;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                phase_hi;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                row_entry;
  logic                swap;
  logic [COLS-1:0]     cur_row;

  // First cycle of SHIFT for the current row: every counter sits at its start value.
  assign row_entry = (state == ST_SHIFT) && (bit_cnt == BIT_W'(COLS - 1)) &&
                     (div_cnt == '0) && !phase_hi;
  assign swap      = row_entry && (row == 4'd0) && pending;

  // On the swap cycle the outgoing bit must already come from the incoming frame.
  assign src_frame = swap ? shadow : display;

  always_comb begin
    cur_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == 4'(r)) cur_row = src_frame[(ROWS-1-r)*COLS +: COLS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SHIFT;
      shadow      <= '0;
      display     <= '0;
      pending     <= 1'b0;
      row         <= 4'd0;
      bit_cnt     <= BIT_W'(COLS - 1);
      div_cnt     <= '0;
      phase_hi    <= 1'b0;
      hold_cnt    <= '0;
      sclk        <= 1'b0;
      sdata       <= 1'b0;
      slatch      <= 1'b0;
      row_sel     <= 4'd0;
      row_en      <= 1'b0;
      frame_ack   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_ack   <= frame_valid;
      frame_start <= row_entry && (row == 4'd0);
      slatch      <= 1'b0;

      // Swap reads the pre-capture shadow; a coinciding capture stays pending.
      if (frame_valid) shadow  <= frame_in;
      if (swap)        display <= shadow;
      pending <= frame_valid | (pending & ~swap);

      case (state)
        ST_SHIFT: begin
          sclk  <= phase_hi;
          sdata <= cur_row[bit_cnt];
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (phase_hi) begin
              phase_hi <= 1'b0;
              if (bit_cnt == '0) begin
                bit_cnt <= BIT_W'(COLS - 1);
                state   <= ST_BLANK;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end else begin
              phase_hi <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          sclk   <= 1'b0;
          row_en <= 1'b0;
          state  <= ST_LATCH;
        end
        ST_LATCH: begin
          slatch   <= 1'b1;
          row_en   <= 1'b0;
          row_sel  <= row;
          hold_cnt <= '0;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          row_en <= 1'b1;
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            row      <= (row == 4'(ROWS - 1)) ? 4'd0 : row + 4'd1;
            state    <= ST_SHIFT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: a negedge monitor decodes the serial stream
// into latched rows; scenario tasks push expected rows and compare them.
module tb_matrix_scan_driver;

  localparam int COLS    = 16;
  localparam int ROWS    = 12;
  localparam int CLK_DIV = 2;
  localparam int HOLD    = 64;
  localparam int ROW_P   = 2*CLK_DIV*COLS + 2 + HOLD;
  localparam int FRAME_P = ROWS * ROW_P;
  localparam int FW      = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ack, frame_start, sclk, sdata, slatch, row_en;
  logic [3:0]    row_sel;

  always #5 clk = ~clk;

  matrix_scan_driver #(.COLS(COLS), .ROWS(ROWS), .CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .frame_start(frame_start), .sclk(sclk), .sdata(sdata),
    .slatch(slatch), .row_sel(row_sel), .row_en(row_en)
  );

  typedef struct { logic [3:0] row; logic [COLS-1:0] data; int nbits; int fs; } obs_t;
  typedef struct { logic [3:0] row; logic [COLS-1:0] data; } exp_t;

  obs_t obs[$];
  exp_t exp_q[$];
  int   lat_iv[$], fs_iv[$], hi_runs[$], lo_runs[$];
  int   compared = 0, mismatched = 0, rd = 0;
  logic [FW-1:0] cur_disp = '0;

  logic            prev_sclk = 1'b0;
  logic [COLS-1:0] word = '0;
  int nbits = 0, hi_run = 0, lo_run = 0, cyc = 0, last_lat = -1, last_fs = -1;
  int fs_cnt = 0, latch_cnt = 0, hold_left = 0, rowen_viol = 0;
  bit seen_latch = 1'b0;

  always @(negedge clk) begin
    obs_t o;
    cyc++;
    if (!rst_n) begin
      prev_sclk = 1'b0; word = '0; nbits = 0; hi_run = 0; lo_run = 0;
      last_lat = -1; last_fs = -1; hold_left = 0; seen_latch = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        word = {word[COLS-2:0], sdata};
        if (nbits > 0) lo_runs.push_back(lo_run);
        nbits++;
        lo_run = 0;
      end
      if (!sclk && prev_sclk) begin
        hi_runs.push_back(hi_run);
        hi_run = 0;
      end
      if (sclk) hi_run++; else lo_run++;
      if (row_en && !seen_latch) rowen_viol++;
      if (slatch) begin
        if (row_en) rowen_viol++;
        o.row = row_sel; o.data = word; o.nbits = nbits; o.fs = fs_cnt;
        obs.push_back(o);
        if (last_lat >= 0) lat_iv.push_back(cyc - last_lat);
        last_lat = cyc; nbits = 0; latch_cnt++; seen_latch = 1'b1; hold_left = HOLD;
      end else if (hold_left > 0) begin
        if (!row_en) rowen_viol++;
        hold_left--;
      end
      if (frame_start) begin
        if (last_fs >= 0) fs_iv.push_back(cyc - last_fs);
        last_fs = cyc;
        fs_cnt++;
      end
      prev_sclk = sclk;
    end
  end

  function automatic logic [FW-1:0] mk_frame(input logic [7:0] seed);
    logic [FW-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[(ROWS-1-r)*COLS +: COLS] = {seed, 4'(r), ~4'(r)};
    return f;
  endfunction

  task automatic push_frame(input logic [FW-1:0] f, input int nrows);
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      e.row = 4'(r);
      e.data = f[(ROWS-1-r)*COLS +: COLS];
      exp_q.push_back(e);
    end
  endtask

  task automatic sync_frame(output bit ok, output int waited);
    ok = 1'b0; waited = 0;
    while (waited < 2*FRAME_P) begin
      @(negedge clk);
      waited++;
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
    end
    rd = obs.size();
  endtask

  task automatic wait_obs(input int n);
    int b = 0;
    while (obs.size() < rd + n && b < (n + 2) * ROW_P + 2*FRAME_P) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic drive_frame(input logic [FW-1:0] f);
    @(negedge clk);
    frame_in = f; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b0; frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    got = {sclk, sdata, slatch, row_en, row_sel, frame_ack, frame_start};
    compared++;
    if (got !== 10'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b required 0000000000", got);
    end
  endtask

  task automatic test_basic();
    bit ok; int w, v0; logic [FW-1:0] f;
    v0 = rowen_viol;
    @(negedge clk) rst_n = 1'b1;
    sync_frame(ok, w);
    compared++;
    if (!ok || w > 2) begin
      mismatched++;
      $display("FAIL first_frame_start: seen=%0d after %0d cycles, required within 2", ok, w);
    end
    f = '0; f[FW-1 -: COLS] = 16'hA5C3;
    push_frame('0, ROWS);
    push_frame(f, ROWS);
    cur_disp = f;
    @(negedge clk) begin frame_in = f; frame_valid = 1'b1; end
    @(negedge clk) frame_valid = 1'b0;
    compared++;
    if (frame_ack !== 1'b1) begin mismatched++; $display("FAIL ack_pulse: got %b required 1", frame_ack); end
    @(negedge clk);
    compared++;
    if (frame_ack !== 1'b0) begin mismatched++; $display("FAIL ack_single: got %b required 0", frame_ack); end
    wait_obs(2*ROWS);
    for (int i = 0; i < 2*ROWS; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL basic_row%0d: no latch, required row %0d data %h", i, e.row, e.data);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data || o.nbits != COLS) begin
          mismatched++;
          $display("FAIL basic_row%0d: got row %0d data %h bits %0d, required row %0d data %h bits %0d",
                   i, o.row, o.data, o.nbits, e.row, e.data, COLS);
        end
      end
    end
    compared++;
    if (rowen_viol != v0) begin
      mismatched++; $display("FAIL row_en_window: got %0d violations, required 0", rowen_viol - v0);
    end
  endtask

  task automatic test_timing();
    bit ok; int w, s_lat, s_fs, s_hi, s_lo, bad;
    sync_frame(ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL timing_sync: frame_start not seen in %0d cycles", w); end
    s_lat = lat_iv.size(); s_fs = fs_iv.size(); s_hi = hi_runs.size(); s_lo = lo_runs.size();
    push_frame(cur_disp, ROWS);
    push_frame(cur_disp, 1);
    wait_obs(ROWS + 1);
    for (int i = 0; i < ROWS + 1; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL timing_row%0d: no latch, required row %0d", i, e.row);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data) begin
          mismatched++;
          $display("FAIL timing_row%0d: got row %0d data %h, required row %0d data %h", i, o.row, o.data, e.row, e.data);
        end
      end
    end
    bad = 0;
    for (int i = s_lat; i < lat_iv.size(); i++) if (lat_iv[i] != ROW_P) bad++;
    compared++;
    if (bad != 0 || lat_iv.size() - s_lat < ROWS) begin
      mismatched++; $display("FAIL latch_spacing: %0d of %0d intervals off, required all %0d", bad, lat_iv.size() - s_lat, ROW_P);
    end
    compared++;
    if (fs_iv.size() <= s_fs) begin
      mismatched++; $display("FAIL frame_period: no second frame_start, required period %0d", FRAME_P);
    end else if (fs_iv[s_fs] != FRAME_P) begin
      mismatched++; $display("FAIL frame_period: got %0d required %0d", fs_iv[s_fs], FRAME_P);
    end
    bad = 0;
    for (int i = s_hi; i < hi_runs.size(); i++) if (hi_runs[i] != CLK_DIV) bad++;
    compared++;
    if (bad != 0 || hi_runs.size() - s_hi < COLS) begin
      mismatched++; $display("FAIL sclk_high: %0d of %0d phases off, required %0d clks", bad, hi_runs.size() - s_hi, CLK_DIV);
    end
    bad = 0;
    for (int i = s_lo; i < lo_runs.size(); i++) if (lo_runs[i] != CLK_DIV) bad++;
    compared++;
    if (bad != 0 || lo_runs.size() - s_lo < COLS - 1) begin
      mismatched++; $display("FAIL sclk_low: %0d of %0d phases off, required %0d clks", bad, lo_runs.size() - s_lo, CLK_DIV);
    end
  endtask

  task automatic test_midframe();
    bit ok; int w, base; logic [FW-1:0] p2;
    sync_frame(ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL midframe_sync: frame_start not seen in %0d cycles", w); end
    base = rd;
    p2 = mk_frame(8'h5A);
    push_frame(cur_disp, ROWS);
    push_frame(p2, ROWS);
    wait_obs(5);
    repeat (80) @(negedge clk);
    drive_frame(p2);
    cur_disp = p2;
    wait_obs(2*ROWS);
    for (int i = 0; i < 2*ROWS; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL midframe_row%0d: no latch, required row %0d", i, e.row);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data) begin
          mismatched++;
          $display("FAIL midframe_row%0d: got row %0d data %h, required row %0d data %h", i, o.row, o.data, e.row, e.data);
        end
      end
    end
    compared++;
    if (obs.size() < base + 2*ROWS) begin
      mismatched++; $display("FAIL midframe_start: too few latches to check frame_start, required %0d", 2*ROWS);
    end else if (obs[base+ROWS].fs != obs[base+ROWS-1].fs + 1) begin
      mismatched++;
      $display("FAIL midframe_start: got frame_start count %0d before new row 0, required %0d",
               obs[base+ROWS].fs, obs[base+ROWS-1].fs + 1);
    end
  endtask

  task automatic test_collision();
    bit ok; int w; logic [FW-1:0] fa, fb;
    sync_frame(ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL collision_sync: frame_start not seen in %0d cycles", w); end
    fa = mk_frame(8'hC1);
    fb = mk_frame(8'h3E);
    push_frame(cur_disp, ROWS);
    push_frame(fa, ROWS);
    push_frame(fb, ROWS);
    drive_frame(fa);
    repeat (FRAME_P - 3) @(negedge clk);
    frame_in = fb; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    compared++;
    if (frame_start !== 1'b1) begin
      mismatched++; $display("FAIL swap_alignment: frame_start got %b required 1 after swap-cycle capture", frame_start);
    end
    cur_disp = fb;
    wait_obs(3*ROWS);
    for (int i = 0; i < 3*ROWS; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL collision_row%0d: no latch, required row %0d", i, e.row);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data) begin
          mismatched++;
          $display("FAIL collision_row%0d: got row %0d data %h, required row %0d data %h", i, o.row, o.data, e.row, e.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int w; logic [FW-1:0] fx, fy, fz;
    sync_frame(ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL burst_sync: frame_start not seen in %0d cycles", w); end
    fx = mk_frame(8'h11); fy = mk_frame(8'h22); fz = mk_frame(8'h93);
    push_frame(cur_disp, ROWS);
    push_frame(fz, ROWS);
    wait_obs(3);
    @(negedge clk) begin frame_in = fx; frame_valid = 1'b1; end
    @(negedge clk) frame_in = fy;
    compared++;
    if (frame_ack !== 1'b1) begin mismatched++; $display("FAIL burst_ack1: got %b required 1", frame_ack); end
    @(negedge clk) frame_in = fz;
    compared++;
    if (frame_ack !== 1'b1) begin mismatched++; $display("FAIL burst_ack2: got %b required 1", frame_ack); end
    @(negedge clk) frame_valid = 1'b0;
    compared++;
    if (frame_ack !== 1'b1) begin mismatched++; $display("FAIL burst_ack3: got %b required 1", frame_ack); end
    @(negedge clk);
    compared++;
    if (frame_ack !== 1'b0) begin mismatched++; $display("FAIL burst_ack_end: got %b required 0", frame_ack); end
    cur_disp = fz;
    wait_obs(2*ROWS);
    for (int i = 0; i < 2*ROWS; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL burst_row%0d: no latch, required row %0d", i, e.row);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data) begin
          mismatched++;
          $display("FAIL burst_row%0d: got row %0d data %h, required row %0d data %h", i, o.row, o.data, e.row, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_midrow();
    bit ok; int w, lc, v0; logic [9:0] got;
    sync_frame(ok, w);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rstmid_sync: frame_start not seen in %0d cycles", w); end
    wait_obs(7);
    repeat (80) @(negedge clk);
    lc = latch_cnt;
    #2 rst_n = 1'b0;
    #1 got = {sclk, sdata, slatch, row_en, row_sel, frame_ack, frame_start};
    compared++;
    if (got !== 10'd0) begin
      mismatched++; $display("FAIL async_reset: got %b required 0000000000", got);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (latch_cnt != lc) begin
      mismatched++; $display("FAIL reset_no_latch: got %0d extra latches, required 0", latch_cnt - lc);
    end
    v0 = rowen_viol;
    rst_n = 1'b1;
    sync_frame(ok, w);
    compared++;
    if (!ok || w > 2) begin
      mismatched++; $display("FAIL restart_frame_start: seen=%0d after %0d cycles, required within 2", ok, w);
    end
    push_frame('0, ROWS);
    wait_obs(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front();
      compared++;
      if (rd >= obs.size()) begin
        mismatched++; $display("FAIL restart_row%0d: no latch, required row %0d", i, e.row);
      end else begin
        o = obs[rd]; rd++;
        if (o.row !== e.row || o.data !== e.data || o.nbits != COLS) begin
          mismatched++;
          $display("FAIL restart_row%0d: got row %0d data %h bits %0d, required row %0d data %h bits %0d",
                   i, o.row, o.data, o.nbits, e.row, e.data, COLS);
        end
      end
    end
    compared++;
    if (rowen_viol != v0) begin
      mismatched++; $display("FAIL restart_row_en: got %0d violations, required 0", rowen_viol - v0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_midframe();
    test_collision();
    test_back_to_back();
    test_reset_midrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
